// File: rtl/matrix_op_sequencer.sv
// Sequences one matrix operation: metadata snapshot, operand validation, load, ALU run with timeout.
// Optional result/error statistics counters are enabled with `define MATRIX_SEQ_STATS_EN.
module matrix_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_MATRICES   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [3:0]                cmd_a_id,
  input  logic [3:0]                cmd_b_id,
  output logic                      req_list_info,
  input  logic [3*MAX_MATRICES-1:0] list_m_flat,
  input  logic [3*MAX_MATRICES-1:0] list_n_flat,
  input  logic [MAX_MATRICES-1:0]   list_valid_flat,
  output logic                      load_operands,
  output logic [3:0]                operand_a_id,
  output logic [3:0]                operand_b_id,
  output logic                      alu_start,
  output logic [1:0]                alu_op,
  input  logic                      alu_done,
  output logic                      op_done,
  output logic [2:0]                res_m,
  output logic [2:0]                res_n,
  output logic                      busy,
  output logic                      err,
  output logic [1:0]                err_code
`ifdef MATRIX_SEQ_STATS_EN
  ,
  output logic [7:0]                ops_ok_cnt,
  output logic [7:0]                ops_err_cnt
`endif
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_TRANSPOSE = 2'd0;
  localparam logic [1:0] OP_ADD       = 2'd1;
  localparam logic [1:0] OP_MUL       = 2'd2;
  localparam logic [1:0] OP_RSVD      = 2'd3;

  localparam logic [1:0] ERR_BAD_OP   = 2'd0;
  localparam logic [1:0] ERR_BAD_OPND = 2'd1;
  localparam logic [1:0] ERR_DIM      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LIST   = 4'd1,
    S_LWAIT  = 4'd2,
    S_CHECK  = 4'd3,
    S_LOAD   = 4'd4,
    S_LWAIT2 = 4'd5,
    S_START  = 4'd6,
    S_RUN    = 4'd7,
    S_DONE   = 4'd8,
    S_ERROR  = 4'd9
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] m;
    logic [2:0] n;
  } slot_t;

  // Ids at or beyond MAX_MATRICES match no slot and come back invalid.
  function automatic slot_t slot_lookup(
    input logic [3:0]                id,
    input logic [3*MAX_MATRICES-1:0] mf,
    input logic [3*MAX_MATRICES-1:0] nf,
    input logic [MAX_MATRICES-1:0]   vf
  );
    slot_t s;
    s = '0;
    for (int i = 0; i < MAX_MATRICES; i++) begin
      if (id == 4'(i)) begin
        s.valid = vf[i];
        s.m     = mf[3*i +: 3];
        s.n     = nf[3*i +: 3];
      end
    end
    return s;
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic [3:0]     a_id_q, a_id_d, b_id_q, b_id_d;
  logic [2:0]     res_m_q, res_m_d, res_n_q, res_n_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic           req_list_q, req_list_d, load_q, load_d, start_q, start_d;
  logic           done_q, done_d, err_q, err_d;
  logic           accept_s, a_ok_s, b_ok_s, chk_fail_s;
  logic [1:0]     chk_code_s;
  logic [2:0]     chk_m_s, chk_n_s;
  slot_t          slot_a_s, slot_b_s;

  assign accept_s = cmd_valid && cmd_ready_q;
  assign slot_a_s = slot_lookup(a_id_q, list_m_flat, list_n_flat, list_valid_flat);
  assign slot_b_s = slot_lookup(b_id_q, list_m_flat, list_n_flat, list_valid_flat);
  assign a_ok_s   = (int'(a_id_q) < MAX_MATRICES) && slot_a_s.valid;
  assign b_ok_s   = (int'(b_id_q) < MAX_MATRICES) && slot_b_s.valid;

  // Operand validation and result-dimension computation, priority ordered.
  always_comb begin
    chk_fail_s = 1'b0;
    chk_code_s = ERR_BAD_OP;
    chk_m_s    = 3'd0;
    chk_n_s    = 3'd0;
    if (op_q == OP_RSVD) begin
      chk_fail_s = 1'b1;
      chk_code_s = ERR_BAD_OP;
    end else if (!a_ok_s) begin
      chk_fail_s = 1'b1;
      chk_code_s = ERR_BAD_OPND;
    end else if ((op_q != OP_TRANSPOSE) && !b_ok_s) begin
      chk_fail_s = 1'b1;
      chk_code_s = ERR_BAD_OPND;
    end else begin
      case (op_q)
        OP_ADD: begin
          if ((slot_a_s.m == slot_b_s.m) && (slot_a_s.n == slot_b_s.n)) begin
            chk_m_s = slot_a_s.m;
            chk_n_s = slot_a_s.n;
          end else begin
            chk_fail_s = 1'b1;
            chk_code_s = ERR_DIM;
          end
        end
        OP_MUL: begin
          if (slot_a_s.n == slot_b_s.m) begin
            chk_m_s = slot_a_s.m;
            chk_n_s = slot_b_s.n;
          end else begin
            chk_fail_s = 1'b1;
            chk_code_s = ERR_DIM;
          end
        end
        OP_TRANSPOSE: begin
          chk_m_s = slot_a_s.n;
          chk_n_s = slot_a_s.m;
        end
        default: begin
          chk_fail_s = 1'b1;
          chk_code_s = ERR_BAD_OP;
        end
      endcase
    end
  end

  // Run-phase cycle counter; cleared on ALU start.
  always_comb begin
    if (state_q == S_START) begin
      cnt_d = '0;
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a done strobe in the final RUN cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = accept_s ? S_LIST : S_IDLE;
      S_LIST:   state_d = S_LWAIT;
      S_LWAIT:  state_d = S_CHECK;
      S_CHECK:  state_d = chk_fail_s ? S_ERROR : S_LOAD;
      S_LOAD:   state_d = S_LWAIT2;
      S_LWAIT2: state_d = S_START;
      S_START:  state_d = S_RUN;
      S_RUN: begin
        if (alu_done) begin
          state_d = S_DONE;
        end else if (cnt_d == TO_LAST) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:   state_d = S_IDLE;
      S_ERROR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output next-values: strobes follow the state being entered so they line up with it.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    req_list_d  = (state_d == S_LIST);
    load_d      = (state_d == S_LOAD);
    start_d     = (state_d == S_START);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERROR);
    if (accept_s) begin
      op_d   = cmd_op;
      a_id_d = cmd_a_id;
      b_id_d = cmd_b_id;
    end else begin
      op_d   = op_q;
      a_id_d = a_id_q;
      b_id_d = b_id_q;
    end
    if (accept_s) begin
      err_code_d = ERR_BAD_OP;
    end else if (state_d == S_ERROR) begin
      err_code_d = (state_q == S_RUN) ? ERR_TIMEOUT : chk_code_s;
    end else begin
      err_code_d = err_code_q;
    end
    if ((state_q == S_CHECK) && !chk_fail_s) begin
      res_m_d = chk_m_s;
      res_n_d = chk_n_s;
    end else begin
      res_m_d = res_m_q;
      res_n_d = res_n_q;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      op_q        <= 2'd0;
      a_id_q      <= 4'd0;
      b_id_q      <= 4'd0;
      res_m_q     <= 3'd0;
      res_n_q     <= 3'd0;
      err_code_q  <= 2'd0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      req_list_q  <= 1'b0;
      load_q      <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_id_q      <= a_id_d;
      b_id_q      <= b_id_d;
      res_m_q     <= res_m_d;
      res_n_q     <= res_n_d;
      err_code_q  <= err_code_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      req_list_q  <= req_list_d;
      load_q      <= load_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign req_list_info = req_list_q;
  assign load_operands = load_q;
  assign alu_start     = start_q;
  assign op_done       = done_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign alu_op        = op_q;
  assign operand_a_id  = a_id_q;
  assign operand_b_id  = b_id_q;
  assign res_m         = res_m_q;
  assign res_n         = res_n_q;

`ifdef MATRIX_SEQ_STATS_EN
  logic [7:0] ok_cnt_q, err_cnt_q;

  // Saturating outcome counters, stepped alongside the op_done / err strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_cnt_q  <= 8'd0;
      err_cnt_q <= 8'd0;
    end else begin
      if ((state_d == S_DONE) && (ok_cnt_q != 8'hFF)) begin
        ok_cnt_q <= ok_cnt_q + 8'd1;
      end
      if ((state_d == S_ERROR) && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign ops_ok_cnt  = ok_cnt_q;
  assign ops_err_cnt = err_cnt_q;
`endif

endmodule
